// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and constants for the LFSR random byte controller
//
// Contents:
//   lfsr_state_e   : controller FSM state encoding
//   CFG_ADDR_*     : configuration register addresses on cfg_addr
//   RST_*          : power-on / reset values of config registers and LFSR state
package lfsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WARM    = 3'd2,
        ST_GEN     = 3'd3,
        ST_PRESENT = 3'd4
    } lfsr_state_e;

    localparam logic [1:0] CFG_ADDR_SEED = 2'd0;
    localparam logic [1:0] CFG_ADDR_TAPS = 2'd1;
    localparam logic [1:0] CFG_ADDR_BLEN = 2'd2;
    localparam logic [1:0] CFG_ADDR_RSVD = 2'd3;

    localparam logic [15:0] RST_SEED  = 16'h0001;
    localparam logic [15:0] RST_TAPS  = 16'hB400;
    localparam logic [7:0]  RST_BLEN  = 8'd16;
    localparam logic [15:0] RST_STATE = 16'h0001;

endpackage

// File: rtl/lfsr_ctrl_if.sv
// rtl/lfsr_ctrl_if.sv - config, control and byte-stream signals of lfsr_ctrl
//
// Signals:
//   cfg_we, cfg_addr, cfg_wdata : config register write port
//   start, abort                : burst control
//   rnd_data, rnd_valid         : random byte stream out, rnd_ready from sink
//   io_oeb                      : pad output enables (active-low)
//   busy, done                  : status
// Modports:
//   master : the controlling side (drives config/control/ready)
//   slave  : the lfsr_ctrl block
interface lfsr_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_wdata;
    logic             start;
    logic             abort;
    logic [7:0]       rnd_data;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [7:0]       io_oeb;
    logic             busy;
    logic             done;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, abort, rnd_ready,
        input  rnd_data, rnd_valid, io_oeb, busy, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, abort, rnd_ready,
        output rnd_data, rnd_valid, io_oeb, busy, done
    );
endinterface

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci-style LFSR register with load and step controls
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (state resets to 1)
//   i_load     : load i_seed into the state (has priority over i_step)
//   i_step     : advance one LFSR step
//   i_seed     : value loaded on i_load
//   i_taps     : feedback tap mask
//   o_state    : current LFSR state
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [WIDTH-1:0] i_taps,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;
    logic             w_fb;

    // Feedback is the parity of the tapped bits; it enters at the LSB.
    assign w_fb = ^(r_state & i_taps);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WIDTH'(RST_STATE);
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= {r_state[WIDTH-2:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/lfsr_ctrl.sv
// rtl/lfsr_ctrl.sv - burst controller producing LFSR random bytes over a valid/ready stream
//
// Ports:
//   wb_clk_i  : clock
//   wb_rst_ni : asynchronous active-low reset
//   bus       : lfsr_ctrl_if.slave (config writes, start/abort, byte stream, pad enables, status)
// Parameters:
//   WIDTH  : LFSR state/seed/tap width
//   WARMUP : LFSR steps discarded after each seed load (0 = none)
module lfsr_ctrl
    import lfsr_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int WARMUP = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    lfsr_ctrl_if.slave  bus
);

    // One shared step counter covers both the warm-up phase and the 8-step byte phase.
    localparam int STEP_MAX = (WARMUP > 8) ? WARMUP : 8;
    localparam int CW       = $clog2(STEP_MAX + 1);
    localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? (WARMUP - 1) : 0);
    localparam logic [CW-1:0] GEN_LAST  = CW'(7);

    lfsr_state_e      r_state;
    lfsr_state_e      w_state_next;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_taps;
    logic [7:0]       r_blen;
    logic [7:0]       r_byte_cnt;
    logic [CW-1:0]    r_step_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_lfsr;
    logic             w_load;
    logic             w_step;
    logic             w_hs;
    logic             w_busy;
    logic             w_valid;
    logic [7:0]       w_byte_cnt_inc;
    logic             w_last_byte;
    logic             w_cfg_en;
    logic             w_unused_state;

    assign w_busy  = (r_state != ST_IDLE);
    assign w_valid = (r_state == ST_PRESENT);
    assign w_hs    = w_valid & bus.rnd_ready;

    // 8-bit wrap makes blen=0 complete after the 256th byte.
    assign w_byte_cnt_inc = r_byte_cnt + 8'd1;
    assign w_last_byte    = (w_byte_cnt_inc == r_blen);

    assign w_cfg_en = bus.cfg_we & ~w_busy;

    // ------------------------------------------------------------------
    // FSM next state and LFSR controls. abort suppresses load/step so the
    // LFSR keeps its value when a burst is cut short.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_load       = 1'b1;
                    w_state_next = (WARMUP > 0) ? ST_WARM : ST_GEN;
                end
            end
            ST_WARM: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_step_cnt == WARM_LAST) begin
                        w_state_next = ST_GEN;
                    end
                end
            end
            ST_GEN: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_step_cnt == GEN_LAST) begin
                        w_state_next = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_hs) begin
                    w_state_next = w_last_byte ? ST_IDLE : ST_GEN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Step counter restarts on every state change so each phase counts from 0.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_step_cnt <= '0;
        end else if (r_state != w_state_next) begin
            r_step_cnt <= '0;
        end else if (w_step) begin
            r_step_cnt <= r_step_cnt + CW'(1);
        end
    end

    // A handshake coinciding with abort still counts as delivered, but only
    // a normal final handshake raises done.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_byte_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_load) begin
                r_byte_cnt <= '0;
            end else if (w_hs) begin
                r_byte_cnt <= w_byte_cnt_inc;
            end
            r_done <= w_hs & w_last_byte & ~bus.abort;
        end
    end

    // Config registers are writable only while idle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_seed <= WIDTH'(RST_SEED);
            r_taps <= WIDTH'(RST_TAPS);
            r_blen <= RST_BLEN;
        end else if (w_cfg_en) begin
            case (bus.cfg_addr)
                CFG_ADDR_SEED: r_seed <= (bus.cfg_wdata == '0) ? WIDTH'(1) : bus.cfg_wdata;
                CFG_ADDR_TAPS: r_taps <= bus.cfg_wdata;
                CFG_ADDR_BLEN: r_blen <= bus.cfg_wdata[7:0];
                CFG_ADDR_RSVD: ;
                default: ;
            endcase
        end
    end

    lfsr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_seed  (r_seed),
        .i_taps  (r_taps),
        .o_state (w_lfsr)
    );

    // Only the low byte reaches the pads.
    assign w_unused_state = ^w_lfsr[WIDTH-1:8];

    assign bus.rnd_valid = w_valid;
    assign bus.rnd_data  = w_valid ? w_lfsr[7:0] : 8'h00;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.io_oeb    = w_busy ? 8'h00 : 8'hFF;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb/tb_lfsr_ctrl.sv - scoreboard testbench for lfsr_ctrl
module tb_lfsr_ctrl;

    localparam int WIDTH  = 16;
    localparam int WARMUP = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_ctrl_if #(.WIDTH(WIDTH)) bus ();

    lfsr_ctrl #(
        .WIDTH  (WIDTH),
        .WARMUP (WARMUP)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] m_seed = 16'h0001;
    logic [15:0] m_taps = 16'hB400;
    logic [7:0]  m_blen = 8'd16;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference: next state = shift left, new LSB = parity of tapped bits.
    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [15:0] t);
        int ones;
        ones = $countones(s & t);
        return (s << 1) | 16'(ones % 2);
    endfunction

    task automatic push_burst();
        logic [15:0] s;
        int nbytes;
        s = m_seed;
        for (int i = 0; i < WARMUP; i++) s = model_step(s, m_taps);
        nbytes = (m_blen == 8'd0) ? 256 : int'(m_blen);
        for (int b = 0; b < nbytes; b++) begin
            for (int k = 0; k < 8; k++) s = model_step(s, m_taps);
            exp_q.push_back(s[7:0]);
        end
    endtask

    // Monitor: scoreboard on handshakes, stream rules every cycle.
    logic       stall_q    = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (!bus.rnd_valid) check("data_zero_when_invalid", 32'(bus.rnd_data), 32'h0);
            if (stall_q) begin
                check("stall_valid_held", 32'(bus.rnd_valid), 32'h1);
                check("stall_data_held", 32'(bus.rnd_data), 32'(stall_data));
            end
            check("oeb_vs_busy", 32'(bus.io_oeb), bus.busy ? 32'h00 : 32'hFF);
            if (bus.rnd_valid && bus.rnd_ready) begin
                hs_cnt <= hs_cnt + 1;
                if (exp_q.size() == 0) fail_now("unexpected_byte");
                else check("byte", 32'(bus.rnd_data), 32'(exp_q.pop_front()));
            end
            if (bus.done) done_cnt <= done_cnt + 1;
            stall_q    <= bus.rnd_valid && !bus.rnd_ready;
            stall_data <= bus.rnd_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data, input bit idle);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we = 1'b0;
        if (idle) begin
            case (addr)
                2'd0: m_seed = (data == 16'h0) ? 16'h0001 : data;
                2'd1: m_taps = data;
                2'd2: m_blen = data[7:0];
                default: ;
            endcase
        end
    endtask

    task automatic pulse_start();
        push_burst();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!bus.rnd_valid && k < budget) begin
            tick();
            k++;
        end
        if (!bus.rnd_valid) fail_now("wait_valid_timeout");
    endtask

    task automatic wait_idle(input int budget, input bit rand_rdy);
        int k;
        k = 0;
        while (bus.busy && k < budget) begin
            if (rand_rdy) bus.rnd_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        if (bus.busy) fail_now("wait_idle_timeout");
        bus.rnd_ready = 1'b1;
    endtask

    task automatic end_checks(input int done_before, input int exp_done);
        tick();
        tick();
        check("done_pulses", 32'(done_cnt - done_before), 32'(exp_done));
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(bus.busy),      32'h0);
        check({tag, "_rnd_valid"}, 32'(bus.rnd_valid), 32'h0);
        check({tag, "_rnd_data"},  32'(bus.rnd_data),  32'h0);
        check({tag, "_io_oeb"},    32'(bus.io_oeb),    32'hFF);
    endtask

    initial begin
        int db;
        int h0;
        int n;

        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.rnd_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        check_idle_outputs("reset");
        check("reset_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic burst: rotate taps, bytes 12 then 34, latency checks
        cfg_write(2'd0, 16'h1234, 1'b1);
        cfg_write(2'd1, 16'h8000, 1'b1);
        cfg_write(2'd2, 16'h0002, 1'b1);
        db = done_cnt;
        pulse_start();
        n = 0;
        while (!bus.rnd_valid && n < 100) begin
            tick();
            n++;
        end
        check("first_valid_latency", 32'(n), 32'(WARMUP + 9));
        check("busy_in_burst", 32'(bus.busy), 32'h1);
        check("oeb_in_burst", 32'(bus.io_oeb), 32'h00);
        tick();
        n = 0;
        while (!bus.rnd_valid && n < 50) begin
            tick();
            n++;
        end
        check("next_valid_latency", 32'(n), 32'h8);
        wait_idle(200, 1'b0);
        end_checks(db, 1);

        // Backpressure for 10 cycles in PRESENT
        bus.rnd_ready = 1'b0;
        db = done_cnt;
        pulse_start();
        wait_valid(100);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(bus.rnd_valid), 32'h1);
            check("bp_data", 32'(bus.rnd_data), 32'h12);
            tick();
        end
        bus.rnd_ready = 1'b1;
        wait_idle(200, 1'b0);
        end_checks(db, 1);

        // Abort during WARM
        db = done_cnt;
        pulse_start();
        repeat (5) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_idle_outputs("abort_warm");
        exp_q.delete();
        tick();
        tick();
        check("abort_warm_no_done", 32'(done_cnt - db), 32'h0);

        // Abort in PRESENT together with a handshake: byte still delivered
        db = done_cnt;
        h0 = hs_cnt;
        pulse_start();
        wait_valid(100);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_idle_outputs("abort_present");
        exp_q.delete();
        tick();
        tick();
        check("abort_present_no_done", 32'(done_cnt - db), 32'h0);
        check("abort_present_hs", 32'(hs_cnt - h0), 32'h1);

        // Seed 0 stores 1; writes while busy are ignored
        cfg_write(2'd0, 16'h0000, 1'b1);
        db = done_cnt;
        pulse_start();
        cfg_write(2'd0, 16'hFFFF, 1'b0);
        cfg_write(2'd1, 16'h1234, 1'b0);
        cfg_write(2'd2, 16'h0007, 1'b0);
        wait_idle(200, 1'b0);
        end_checks(db, 1);
        db = done_cnt;
        pulse_start();
        wait_idle(200, 1'b0);
        end_checks(db, 1);

        // Reserved address write has no effect
        cfg_write(2'd3, 16'h5A5A, 1'b1);

        // blen=0 means 256 bytes
        cfg_write(2'd0, 16'($urandom), 1'b1);
        cfg_write(2'd1, 16'($urandom) | 16'h8000, 1'b1);
        cfg_write(2'd2, 16'h0000, 1'b1);
        db = done_cnt;
        h0 = hs_cnt;
        pulse_start();
        wait_idle(3000, 1'b0);
        check("blen0_handshakes", 32'(hs_cnt - h0), 32'd256);
        end_checks(db, 1);

        // start and abort together in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy0", 32'(bus.busy), 32'h0);
        tick();
        check("start_abort_busy1", 32'(bus.busy), 32'h0);

        // Randomized bursts with random backpressure
        for (int r = 0; r < 6; r++) begin
            cfg_write(2'd0, 16'($urandom), 1'b1);
            cfg_write(2'd1, 16'($urandom), 1'b1);
            cfg_write(2'd2, 16'($urandom_range(1, 6)), 1'b1);
            db = done_cnt;
            pulse_start();
            wait_idle(2000, 1'b1);
            end_checks(db, 1);
        end

        // Reset mid-GEN: immediate reset outputs, defaults restored
        cfg_write(2'd0, 16'hABCD, 1'b1);
        cfg_write(2'd1, 16'h8001, 1'b1);
        cfg_write(2'd2, 16'h0004, 1'b1);
        pulse_start();
        wait_valid(100);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midgen_reset");
        check("midgen_reset_done", 32'(bus.done), 32'h0);
        exp_q.delete();
        tick();
        rst_n  = 1'b1;
        m_seed = 16'h0001;
        m_taps = 16'hB400;
        m_blen = 8'd16;
        db = done_cnt;
        tick();
        tick();
        check("post_reset_no_done", 32'(done_cnt - db), 32'h0);
        db = done_cnt;
        pulse_start();
        wait_idle(400, 1'b0);
        end_checks(db, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, LFSR state/seed/tap width (matches 16-bit io_in[20:5] config field).
REQ-002 Parameter WARMUP, default 16, LFSR steps discarded after seed load; 0 = no warm-up.
REQ-003 wb_clk_i  in  1  single clock; all state on its rising edge.
REQ-004 wb_rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 cfg_we  in  1  config write strobe.
REQ-006 cfg_addr  in  2  0=seed, 1=taps, 2=burst length, 3=reserved (write ignored).
REQ-007 cfg_wdata  in  WIDTH  config write data.
REQ-008 start  in  1  begin burst; sampled only in IDLE.
REQ-009 abort  in  1  terminate current burst.
REQ-010 rnd_data  out  8  random byte to pads io_out[28:21].
REQ-011 rnd_valid  out  1  rnd_data valid.
REQ-012 rnd_ready  in  1  sink accepts byte.
REQ-013 io_oeb  out  8  pad output enable, active-low.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 done  out  1  one-cycle pulse on normal burst completion.

Function
REQ-016 Config regs: seed (WIDTH), taps (WIDTH), blen (8); writes accepted only in IDLE, ignored otherwise.
REQ-017 Seed write of 0 stores 1 (lock-up avoidance).
REQ-018 blen=0 means 256 bytes.
REQ-019 LFSR step: fb = XOR-reduce(state & taps); state <= {state[WIDTH-2:0], fb}.
REQ-020 FSM states IDLE, LOAD, WARM, GEN, PRESENT.
REQ-021 IDLE -> LOAD on start & !abort; LOAD loads state <= seed, clears byte counter, 1 cycle.
REQ-022 LOAD -> WARM (WARMUP>0) or GEN (WARMUP=0); WARM steps once per cycle for exactly WARMUP cycles, then -> GEN.
REQ-023 GEN steps once per cycle for exactly 8 cycles, then -> PRESENT.
REQ-024 PRESENT: rnd_valid=1, rnd_data=state[7:0], both stable until rnd_valid&rnd_ready; no stepping.
REQ-025 On handshake: counter+1; if counter reaches blen -> IDLE with done=1 next cycle, else -> GEN.
REQ-026 First rnd_valid asserts WARMUP+9 rising edges after the edge sampling start; subsequent rnd_valid 8 edges after each handshake edge.
REQ-027 abort in any non-IDLE state -> IDLE next edge; no done; rnd_valid low from that edge; LFSR state held.
REQ-028 abort and start together in IDLE: abort wins, stay IDLE.
REQ-029 abort with handshake same cycle: byte counts as delivered to sink; FSM -> IDLE, no done.
REQ-030 start while busy ignored; cfg_we during busy ignored without side effect.
REQ-031 rnd_data=0 whenever rnd_valid=0.
REQ-032 io_oeb=8'h00 while busy, 8'hFF in IDLE.

Reset
REQ-033 On wb_rst_ni low, immediately: FSM=IDLE, seed=1, taps=16'hB400, blen=16, LFSR state=1, counter=0.
REQ-034 Outputs in reset: rnd_data=0, rnd_valid=0, busy=0, done=0, io_oeb=8'hFF.
REQ-035 Reset mid-burst discards burst; no done pulse on reset release.

Structure
REQ-036 Package lfsr_pkg holds FSM state enum, cfg_addr constants, reset constants (seed, taps, blen).
REQ-037 One sub-module lfsr_core: inputs load, step, seed, taps; output state; holds no FSM.

Verification
REQ-038 Reset values: assert reset mid-GEN -> all outputs at REQ-034 values same cycle, config regs at defaults.
REQ-039 seed=16'h1234, taps=16'h8000, blen=2, WARMUP=16, start -> bytes 8'h12 then 8'h34, first valid 25 edges after start, done one pulse.
REQ-040 Backpressure: same config, rnd_ready low 10 cycles in PRESENT -> rnd_valid/rnd_data stable, no stepping, byte 8'h12 delivered on release.
REQ-041 abort during WARM and during PRESENT (with rnd_ready=1) -> IDLE next edge, done stays 0, io_oeb=8'hFF.
REQ-042 Write seed=0 then start with taps=16'h8000 -> state loaded as 16'h0001; cfg_we while busy leaves regs unchanged.
REQ-043 blen=0, rnd_ready=1 -> exactly 256 handshakes then done; start+abort same cycle in IDLE -> busy stays 0.
